// File: rtl/game_flow_sequencer_if.sv
// game_flow_sequencer_if
//   Signal bundle between the game sequencer and the rest of the game top level.
//   The master side supplies the frame strobe, the player button and the
//   collision/pipe levels. The slave side (the sequencer) returns the game
//   state, the animation gates, the scores and the buzzer request.
//
//   frame_tick  : one-clock strobe per animation frame
//   start_btn   : start/restart request level
//   collision   : bird/pipe overlap level
//   pipe_wrap   : end-of-map level, each rising edge is one pipe passed
//   state       : 0 idle, 1 play, 2 hit, 3 over
//   scroll_en   : pipe/background/cloud motion enable
//   bird_run    : bird flap sprite select
//   score       : current score
//   high_score  : best score since reset
//   tone_en     : buzzer enable
//   tone_freq   : buzzer frequency word
interface game_flow_sequencer_if;
  logic        frame_tick;
  logic        start_btn;
  logic        collision;
  logic        pipe_wrap;
  logic [1:0]  state;
  logic        scroll_en;
  logic        bird_run;
  logic [9:0]  score;
  logic [9:0]  high_score;
  logic        tone_en;
  logic [15:0] tone_freq;

  modport master (
    output frame_tick, start_btn, collision, pipe_wrap,
    input  state, scroll_en, bird_run, score, high_score, tone_en, tone_freq
  );

  modport slave (
    input  frame_tick, start_btn, collision, pipe_wrap,
    output state, scroll_en, bird_run, score, high_score, tone_en, tone_freq
  );
endinterface

// File: rtl/game_flow_sequencer.sv
// game_flow_sequencer
//   Top-level flow for the pipe game: idle -> play -> hit -> over. Gates the
//   scroll animations, keeps the running and high scores and requests buzzer
//   tones (a short chirp per pipe passed, a fixed tone while the hit freeze
//   lasts).
//
//   CLOCK  : system clock
//   reset  : synchronous, active-high
//   bus    : game_flow_sequencer_if slave modport (events in, status out)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset, scene frozen, waits for a start press
//   PLAY  | scrolling, counts pipes, watches collision on frame ticks
//   HIT   | frozen for HIT_FRAMES frame ticks, hit tone on
//   OVER  | score on display, restart accepted after OVER_FRAMES ticks
module game_flow_sequencer #(
  parameter int unsigned HIT_FRAMES   = 30,
  parameter int unsigned OVER_FRAMES  = 120,
  parameter int unsigned CHIRP_FRAMES = 6,
  parameter int unsigned SCORE_MAX    = 999,
  parameter int unsigned TONE_STEP    = 50,
  parameter int unsigned HIT_TONE     = 200
) (
  input logic                  CLOCK,
  input logic                  reset,
  game_flow_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [7:0]  HIT_LD   = 8'(HIT_FRAMES);
  localparam logic [7:0]  OVER_LD  = 8'(OVER_FRAMES);
  localparam logic [7:0]  CHIRP_LD = 8'(CHIRP_FRAMES);
  localparam logic [9:0]  SMAX     = 10'(SCORE_MAX);
  localparam logic [15:0] STEP     = 16'(TONE_STEP);
  localparam logic [15:0] HTONE    = 16'(HIT_TONE);

  state_t      state_q;
  logic        start_prev;
  logic        pipe_prev;
  logic [7:0]  frame_cnt;
  logic [7:0]  chirp_cnt;
  logic [9:0]  score_q;
  logic [9:0]  high_q;
  logic        scroll_q;
  logic        bird_q;
  logic        tone_en_q;
  logic [15:0] tone_freq_q;

  logic        start_rise;
  logic        pipe_rise;
  logic [7:0]  frame_dec;
  logic [7:0]  chirp_dec;
  logic        hit_done;
  logic        collide;
  logic [9:0]  score_inc;
  logic [15:0] score_tone;

  assign start_rise = bus.start_btn & ~start_prev;
  assign pipe_rise  = bus.pipe_wrap & ~pipe_prev;

  assign frame_dec = (bus.frame_tick && frame_cnt != 8'd0) ? frame_cnt - 8'd1 : frame_cnt;
  assign chirp_dec = (bus.frame_tick && chirp_cnt != 8'd0) ? chirp_cnt - 8'd1 : chirp_cnt;

  // The HIT_FRAMES-th tick is the one seen while the counter still holds 1,
  // so leave on that tick rather than a cycle after the counter hits zero.
  assign hit_done = (frame_cnt == 8'd0) || (bus.frame_tick && frame_cnt == 8'd1);

  // Collision only counts on a frame tick; mid-frame glitches are ignored.
  assign collide = bus.frame_tick & bus.collision;

  assign score_inc  = (score_q >= SMAX) ? SMAX : score_q + 10'd1;
  assign score_tone = {6'd0, score_q} * STEP;

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q     <= IDLE;
      start_prev  <= 1'b1;
      pipe_prev   <= 1'b1;
      frame_cnt   <= 8'd0;
      chirp_cnt   <= 8'd0;
      score_q     <= 10'd0;
      high_q      <= 10'd0;
      scroll_q    <= 1'b0;
      bird_q      <= 1'b0;
      tone_en_q   <= 1'b0;
      tone_freq_q <= 16'd0;
    end else begin
      start_prev  <= bus.start_btn;
      pipe_prev   <= bus.pipe_wrap;
      frame_cnt   <= frame_dec;
      chirp_cnt   <= chirp_dec;
      // Chirp tone tracks the registered score and chirp counter; the HIT
      // branches below override it with the fixed hit tone.
      tone_en_q   <= (chirp_cnt != 8'd0);
      tone_freq_q <= score_tone;

      case (state_q)
        IDLE: begin
          scroll_q  <= 1'b0;
          bird_q    <= 1'b0;
          score_q   <= 10'd0;
          chirp_cnt <= 8'd0;
          if (start_rise) begin
            state_q   <= PLAY;
            frame_cnt <= 8'd0;
            scroll_q  <= 1'b1;
            bird_q    <= 1'b1;
          end
        end

        PLAY: begin
          scroll_q <= 1'b1;
          bird_q   <= 1'b1;
          // Collision beats a pipe edge in the same cycle: no final point.
          if (collide) begin
            state_q     <= HIT;
            frame_cnt   <= HIT_LD;
            chirp_cnt   <= 8'd0;
            scroll_q    <= 1'b0;
            bird_q      <= 1'b0;
            tone_en_q   <= 1'b1;
            tone_freq_q <= HTONE;
          end else if (pipe_rise) begin
            score_q   <= score_inc;
            chirp_cnt <= CHIRP_LD;
          end
        end

        HIT: begin
          scroll_q  <= 1'b0;
          bird_q    <= 1'b0;
          chirp_cnt <= 8'd0;
          if (hit_done) begin
            state_q   <= OVER;
            frame_cnt <= OVER_LD;
            if (score_q > high_q) begin
              high_q <= score_q;
            end
          end else begin
            tone_en_q   <= 1'b1;
            tone_freq_q <= HTONE;
          end
        end

        OVER: begin
          scroll_q  <= 1'b0;
          bird_q    <= 1'b0;
          chirp_cnt <= 8'd0;
          // Presses before the display hold has expired are dropped.
          if (start_rise && frame_cnt == 8'd0) begin
            state_q   <= PLAY;
            score_q   <= 10'd0;
            frame_cnt <= 8'd0;
            scroll_q  <= 1'b1;
            bird_q    <= 1'b1;
          end
        end

        default: begin
          state_q   <= IDLE;
          scroll_q  <= 1'b0;
          bird_q    <= 1'b0;
          chirp_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.scroll_en  = scroll_q;
  assign bus.bird_run   = bird_q;
  assign bus.score      = score_q;
  assign bus.high_score = high_q;
  assign bus.tone_en    = tone_en_q;
  assign bus.tone_freq  = tone_freq_q;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// tb_game_flow_sequencer
//   Directed bench for game_flow_sequencer. Stimulus pushes expected output
//   values into a queue tagged with the cycle they apply to; a monitor on the
//   falling edge pops and compares them against the DUT outputs.
module tb_game_flow_sequencer;

  logic CLOCK;
  logic reset;
  int   cyc;
  int   applied;
  int   miscompares;

  game_flow_sequencer_if bus ();

  game_flow_sequencer dut (
    .CLOCK (CLOCK),
    .reset (reset),
    .bus   (bus.slave)
  );

  localparam int F_STATE = 0;
  localparam int F_SCORE = 1;
  localparam int F_HIGH  = 2;
  localparam int F_TEN   = 3;
  localparam int F_TFREQ = 4;
  localparam int F_SCR   = 5;
  localparam int F_BIRD  = 6;

  typedef struct {
    string name;
    int    due;
    int    fld;
    int    val;
  } exp_t;

  exp_t sb[$];

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  function automatic int field_val(input int f);
    case (f)
      F_STATE: return int'(bus.state);
      F_SCORE: return int'(bus.score);
      F_HIGH:  return int'(bus.high_score);
      F_TEN:   return int'(bus.tone_en);
      F_TFREQ: return int'(bus.tone_freq);
      F_SCR:   return int'(bus.scroll_en);
      F_BIRD:  return int'(bus.bird_run);
      default: return -1;
    endcase
  endfunction

  // Monitor: compares every expectation that has come due.
  always @(negedge CLOCK) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      automatic exp_t e = sb.pop_front();
      automatic int   act = field_val(e.fld);
      applied++;
      if (act != e.val) begin
        miscompares++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  task automatic expect_now(input string name, input int fld, input int val);
    exp_t e;
    e.name = name;
    e.due  = cyc;
    e.fld  = fld;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic cyc1();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic ftick();
    bus.frame_tick = 1'b1;
    cyc1();
    bus.frame_tick = 1'b0;
  endtask

  task automatic fticks(input int n);
    for (int i = 0; i < n; i++) ftick();
  endtask

  task automatic pipe();
    bus.pipe_wrap = 1'b1;
    cyc1();
    bus.pipe_wrap = 1'b0;
    cyc1();
  endtask

  task automatic pipes(input int n);
    for (int i = 0; i < n; i++) pipe();
  endtask

  task automatic press();
    bus.start_btn = 1'b1;
    cyc1();
    bus.start_btn = 1'b0;
  endtask

  task automatic collide_tick();
    bus.collision = 1'b1;
    ftick();
    bus.collision = 1'b0;
  endtask

  initial begin
    cyc           = 0;
    applied       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.start_btn = 1'b1;
    bus.frame_tick = 1'b0;
    bus.collision = 1'b0;
    bus.pipe_wrap = 1'b0;
    repeat (3) cyc1();

    expect_now("rst_state", F_STATE, 0);
    expect_now("rst_score", F_SCORE, 0);
    expect_now("rst_high", F_HIGH, 0);
    expect_now("rst_tone_en", F_TEN, 0);
    expect_now("rst_tone_freq", F_TFREQ, 0);
    expect_now("rst_scroll", F_SCR, 0);
    expect_now("rst_bird", F_BIRD, 0);

    // start held through reset must not start the game
    reset = 1'b0;
    repeat (3) cyc1();
    expect_now("held_start_ignored", F_STATE, 0);
    bus.start_btn = 1'b0;
    cyc1();
    expect_now("release_still_idle", F_STATE, 0);
    press();
    expect_now("start_state", F_STATE, 1);
    expect_now("start_scroll", F_SCR, 1);
    expect_now("start_bird", F_BIRD, 1);

    // five pipes, then chirp duration
    pipes(5);
    expect_now("score5", F_SCORE, 5);
    expect_now("tone_freq5", F_TFREQ, 250);
    expect_now("chirp_on", F_TEN, 1);
    fticks(5);
    expect_now("chirp_tick5", F_TEN, 1);
    ftick();
    expect_now("chirp_tick6", F_TEN, 1);
    cyc1();
    expect_now("chirp_off", F_TEN, 0);

    // collision level between frame ticks is ignored
    bus.collision = 1'b1;
    repeat (3) cyc1();
    bus.collision = 1'b0;
    expect_now("glitch_ignored", F_STATE, 1);

    pipes(2);
    expect_now("score7", F_SCORE, 7);
    expect_now("tone_freq7", F_TFREQ, 350);

    // collision and pipe edge together: collision wins
    bus.collision  = 1'b1;
    bus.frame_tick = 1'b1;
    bus.pipe_wrap  = 1'b1;
    cyc1();
    bus.collision  = 1'b0;
    bus.frame_tick = 1'b0;
    bus.pipe_wrap  = 1'b0;
    expect_now("hit_state", F_STATE, 2);
    expect_now("hit_score_frozen", F_SCORE, 7);
    expect_now("hit_scroll", F_SCR, 0);
    expect_now("hit_tone_en", F_TEN, 1);
    expect_now("hit_tone_freq", F_TFREQ, 200);

    // inputs ignored while frozen
    press();
    expect_now("hit_start_ignored", F_STATE, 2);
    pipe();
    expect_now("hit_pipe_ignored", F_SCORE, 7);
    fticks(29);
    expect_now("hit_29", F_STATE, 2);
    expect_now("hit_29_tone", F_TFREQ, 200);
    ftick();
    expect_now("over_state", F_STATE, 3);
    expect_now("over_high", F_HIGH, 7);
    expect_now("over_score", F_SCORE, 7);
    expect_now("over_tone_en", F_TEN, 0);
    expect_now("over_tone_freq", F_TFREQ, 350);

    // restart hold-off
    fticks(50);
    press();
    expect_now("over_50_ignored", F_STATE, 3);
    fticks(69);
    press();
    expect_now("over_119_ignored", F_STATE, 3);
    ftick();
    press();
    expect_now("restart_state", F_STATE, 1);
    expect_now("restart_score", F_SCORE, 0);
    expect_now("restart_high", F_HIGH, 7);
    expect_now("restart_scroll", F_SCR, 1);

    // lower-scoring game keeps the high score
    pipes(3);
    expect_now("g2_score3", F_SCORE, 3);
    expect_now("g2_tone_freq", F_TFREQ, 150);
    collide_tick();
    expect_now("g2_hit", F_STATE, 2);
    fticks(30);
    expect_now("g2_over", F_STATE, 3);
    expect_now("g2_high_kept", F_HIGH, 7);
    expect_now("g2_score_held", F_SCORE, 3);

    // saturation
    fticks(120);
    press();
    expect_now("g3_start", F_STATE, 1);
    pipes(998);
    expect_now("score998", F_SCORE, 998);
    fticks(7);
    cyc1();
    expect_now("chirp_drained", F_TEN, 0);
    pipe();
    expect_now("score999", F_SCORE, 999);
    expect_now("tone_freq999", F_TFREQ, 49950);
    pipes(2);
    expect_now("score_sat", F_SCORE, 999);
    fticks(7);
    cyc1();
    expect_now("chirp_drained2", F_TEN, 0);
    pipe();
    expect_now("chirp_at_max", F_TEN, 1);
    expect_now("score_sat2", F_SCORE, 999);
    collide_tick();
    fticks(30);
    expect_now("g3_high", F_HIGH, 999);

    // reset during HIT
    fticks(120);
    press();
    pipes(12);
    expect_now("g4_score12", F_SCORE, 12);
    collide_tick();
    expect_now("g4_hit", F_STATE, 2);
    fticks(5);
    reset = 1'b1;
    cyc1();
    reset = 1'b0;
    expect_now("mid_rst_state", F_STATE, 0);
    expect_now("mid_rst_score", F_SCORE, 0);
    expect_now("mid_rst_high", F_HIGH, 0);
    expect_now("mid_rst_tone_en", F_TEN, 0);
    expect_now("mid_rst_tone_freq", F_TFREQ, 0);
    expect_now("mid_rst_scroll", F_SCR, 0);
    expect_now("mid_rst_bird", F_BIRD, 0);
    cyc1();
    press();
    expect_now("post_rst_start", F_STATE, 1);
    cyc1();
    expect_now("post_rst_no_chirp", F_TEN, 0);

    repeat (2) cyc1();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/game_flow_sequencer.md
# game_flow_sequencer

Top-level game sequencer for the side-scrolling pipe game. It owns the IDLE → PLAY → HIT → OVER flow and gates the scroll animations. It keeps the running and high scores and drives the buzzer tone request. It sits between the pipe/background animation blocks, the collision flag from the drawing controller, and the buzzer, replacing the free-running score and edge-triggered score logic in the top level.

## Interface
Parameters:
- HIT_FRAMES, 30: frame ticks spent frozen in HIT before OVER (1..255).
- OVER_FRAMES, 120: minimum frame ticks in OVER before a restart is accepted (1..255).
- CHIRP_FRAMES, 6: frame ticks the score chirp stays on (1..255).
- SCORE_MAX, 999: score saturation value (≤1023).
- TONE_STEP, 50: chirp frequency per score point.
- HIT_TONE, 200: tone frequency during HIT.

Ports:
- CLOCK, in, 1: system clock; the only clock.
- reset, in, 1: synchronous, active-high.
- frame_tick, in, 1: one-CLOCK strobe per animation frame, already synchronous to CLOCK.
- start_btn, in, 1: start/restart request, active-high level, synchronous.
- collision, in, 1: bird/pipe overlap level from the drawing controller.
- pipe_wrap, in, 1: end-of-map level from the pipe animator; each rising edge is one pipe passed.
- state, out, 2: 0 IDLE, 1 PLAY, 2 HIT, 3 OVER.
- scroll_en, out, 1: enables pipe/background/cloud motion.
- bird_run, out, 1: selects the bird flap sprite set.
- score, out, 10: current score.
- high_score, out, 10: best score since reset.
- tone_en, out, 1: buzzer enable.
- tone_freq, out, 16: buzzer frequency word.

## Operation
- Edge detectors: start_prev and pipe_prev are registered. Both reset to 1, so an input held high through reset must fall before it can trigger. start_rise = start_btn & ~start_prev. pipe_rise = pipe_wrap & ~pipe_prev.
- frame_cnt is 8 bits. It is loaded on state entry and decremented on frame_tick while nonzero.
- IDLE: scroll_en=0, bird_run=0, score=0. start_rise → PLAY.
- PLAY: scroll_en=1, bird_run=1.
  - pipe_rise: score = min(score+1, SCORE_MAX); chirp counter loaded with CHIRP_FRAMES.
  - collision is sampled only in a cycle with frame_tick=1. If high → HIT, frame_cnt=HIT_FRAMES.
- HIT: scroll_en=0, bird_run=0, score frozen. Inputs are ignored. When frame_cnt reaches 0 → OVER, frame_cnt=OVER_FRAMES, and high_score = max(high_score, score) is written in the same cycle.
- OVER: scroll_en=0, score held for display.
  - start_rise with frame_cnt=0 → PLAY, score=0 in the same cycle.
  - start_rise with frame_cnt≠0 is discarded.
- Tone:
  - HIT: tone_en=1, tone_freq=HIT_TONE.
  - Otherwise: tone_en=(chirp_cnt≠0), tone_freq=score×TONE_STEP, computed at 16 bits and truncated.
  - chirp_cnt decrements on frame_tick and is forced to 0 on leaving PLAY.
- Simultaneous events:
  - In PLAY, if collision is sampled in the same cycle as pipe_rise, collision wins: → HIT, no increment.
  - pipe_rise at SCORE_MAX still loads the chirp.
- Any unused encoding decodes to IDLE.

## Timing
- All outputs are registered. Outputs change in the cycle after the qualifying input sample, in lockstep with state.
- Reset values (synchronous, from the cycle after reset is sampled high): state=IDLE, scroll_en=0, bird_run=0, score=0, high_score=0, tone_en=0, tone_freq=0, frame_cnt=0, chirp_cnt=0.
- Reset mid-game aborts immediately with no high_score update. A pending chirp is cleared.
- Start latency: start_rise at cycle n → state=PLAY and scroll_en=1 at n+1.
- HIT → OVER occurs on the cycle after the HIT_FRAMES-th frame_tick counted in HIT.
- Score increment is visible at n+1 for pipe_rise at n. tone_freq follows one cycle later, from the registered score.
- Between frame_ticks, collision is never looked at. Glitches inside a frame cannot end the game.

## Test plan
- Reset with start_btn held high, then release and press: no start until the press → state=1 one cycle after the rising edge, scroll_en=1.
- PLAY, five pipe_wrap pulses → score=5, tone_freq=250, tone_en high for 6 frame_ticks after the last pulse.
- Collision asserted on a frame_tick together with a pipe_wrap edge, score=7 → state=2, score stays 7, tone_freq=200. After 30 frame_ticks → state=3, high_score=7.
- OVER: press start after 50 frame_ticks → ignored. Press after 120 → state=1, score=0, high_score=7. Next game ends at score 3 → high_score remains 7.
- Force score to 998, three pipe edges → score saturates at 999. Chirp still asserts.
- Assert reset during HIT with score=12 → all outputs 0 next cycle, high_score=0.
